vedic_mac_acc: RTL and testbench

Multiply-accumulate sequencer wrapped around the combinational 32x32 Vedic multiplier. It accepts operand pairs over a valid/ready handshake and registers them onto the multiplier inputs. It captures the 64-bit product one cycle later and sums ACC_LEN products into a guarded accumulator. The frame result is then presented on a valid/ready output port. It sits directly upstream and downstream of the multiplier: it drives its operands and consumes its product.

---
 rtl/vedic_mac_acc.sv | 153 +++++++++++++++
 tb/tb_vedic_mac_acc.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_mac_acc.sv
// MAC sequencer around an external combinational 32x32 Vedic multiplier:
// registers operands, captures the product, and sums ACC_LEN products per frame.
module vedic_mac_acc #(
  parameter int unsigned ACC_LEN = 16,
  parameter int unsigned GUARD   = 8,
  localparam int unsigned OP_W   = 32,
  localparam int unsigned PROD_W = 64,
  localparam int unsigned ACC_W  = PROD_W + GUARD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic [PROD_W-1:0] mul_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic {RUN, HOLD} state_e;

  state_e              state_q, state_d;
  logic [OP_W-1:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic                s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PROD_W-1:0]   p_q, p_d;
  logic                s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_out_q, acc_out_d;
  logic                ovf_q, ovf_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [ACC_W:0]      sum;
  logic                accept;

  // State and pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      s1_vld_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      cnt_q       <= '0;
      p_q         <= '0;
      s2_vld_q    <= 1'b0;
      s2_last_q   <= 1'b0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      s1_vld_q    <= s1_vld_d;
      s1_last_q   <= s1_last_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      s2_vld_q    <= s2_vld_d;
      s2_last_q   <= s2_last_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state: operand stage, product stage, accumulate/hold FSM, clr override
  always_comb begin
    state_d   = state_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    s1_vld_d  = 1'b0;
    s1_last_d = 1'b0;
    cnt_d     = cnt_q;
    p_d       = mul_p;
    s2_vld_d  = s1_vld_q;
    s2_last_d = s1_last_q;
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    ovf_d     = ovf_q;
    sum       = {1'b0, acc_q} + (ACC_W+1)'(p_q);
    accept    = in_valid && in_ready_q;

    if (accept) begin
      mul_a_d   = in_a;
      mul_b_d   = in_b;
      s1_vld_d  = 1'b1;
      s1_last_d = (cnt_q == CNT_W'(ACC_LEN - 1));
      cnt_d     = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      RUN: begin
        if (s2_vld_q) begin
          acc_d = sum[ACC_W-1:0];
          if (sum[ACC_W]) ovf_d = 1'b1;
          if (s2_last_q) begin
            acc_out_d = sum[ACC_W-1:0];
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d   = RUN;
          acc_d     = '0;
          acc_out_d = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase

    // Abort discards any in-flight products and a pending result
    if (clr) begin
      state_d   = RUN;
      mul_a_d   = '0;
      mul_b_d   = '0;
      s1_vld_d  = 1'b0;
      s1_last_d = 1'b0;
      cnt_d     = '0;
      p_d       = '0;
      s2_vld_d  = 1'b0;
      s2_last_d = 1'b0;
      acc_d     = '0;
      acc_out_d = '0;
      ovf_d     = 1'b0;
    end

    out_valid_d = (state_d == HOLD);
    in_ready_d  = !clr && (state_d == RUN) && (cnt_d < CNT_W'(ACC_LEN));
  end

  assign in_ready  = in_ready_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_valid = out_valid_q;
  assign acc_out   = acc_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_vedic_mac_acc.sv
// Scoreboard bench for vedic_mac_acc: three instances (ACC_LEN/GUARD = 4/8, 2/0, 3/8)
// driven one at a time; a monitor checks every result handshake against a queue.
module tb_vedic_mac_acc;

  localparam int NI = 3;

  typedef struct {
    int          inst;
    logic [71:0] acc;
    logic        ovf;
    int          rise;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr       [NI];
  logic        in_valid  [NI];
  logic        in_ready  [NI];
  logic [31:0] in_a      [NI];
  logic [31:0] in_b      [NI];
  logic [31:0] mul_a     [NI];
  logic [31:0] mul_b     [NI];
  logic [63:0] mul_p     [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic [71:0] acc_out   [NI];
  logic        ovf       [NI];

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  int   last_acc;
  int   hs_cnt   [NI];
  int   rise_cyc [NI];
  logic prev_ov  [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 4 : ((g == 1) ? 2 : 3);
    localparam int unsigned G = (g == 1) ? 0 : 8;
    logic [64+G-1:0] acc_w;
    vedic_mac_acc #(.ACC_LEN(L), .GUARD(G)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_a     (in_a[g]),
      .in_b     (in_b[g]),
      .mul_a    (mul_a[g]),
      .mul_b    (mul_b[g]),
      .mul_p    (mul_p[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .acc_out  (acc_w),
      .ovf      (ovf[g])
    );
    assign acc_out[g] = 72'(acc_w);
    assign mul_p[g]   = {32'b0, mul_a[g]} * {32'b0, mul_b[g]};
  end

  task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Result monitor: first out_valid cycle and handshake contents
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (out_valid[i] && !prev_ov[i]) rise_cyc[i] = cyc;
      prev_ov[i] = out_valid[i];
      if (out_valid[i] && out_ready[i]) begin
        hs_cnt[i]++;
        if (exp_q.size() == 0) begin
          chk("unexpected_result", acc_out[i], 72'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result_inst", 72'(i), 72'(e.inst));
          chk("acc_out", acc_out[i], e.acc);
          chk("ovf", 72'(ovf[i]), 72'(e.ovf));
          chk("latency", 72'(rise_cyc[i]), 72'(e.rise));
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send(input int i, input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok = 1'b0;
    in_valid[i] = 1'b1;
    in_a[i] = a;
    in_b[i] = b;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready[i]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("send");
    @(posedge clk); #1;
    last_acc = cyc;
    in_valid[i] = 1'b0;
  endtask

  task automatic push(input int i, input logic [71:0] acc, input logic o);
    exp_q.push_back('{inst: i, acc: acc, ovf: o, rise: last_acc + 2});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 80 && exp_q.size() != 0; n++) tick(1);
    if (exp_q.size() != 0) timeout("drain");
  endtask

  task automatic wait_ov(input int i);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid[i]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("wait_out_valid");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      clr[i] = 1'b0; in_valid[i] = 1'b0; in_a[i] = '0; in_b[i] = '0;
      out_ready[i] = 1'b1; hs_cnt[i] = 0; rise_cyc[i] = 0; prev_ov[i] = 1'b0;
    end
    tick(3);
    chk("rst_in_ready", 72'(in_ready[0]), 72'h0);
    chk("rst_out_valid", 72'(out_valid[0]), 72'h0);
    chk("rst_acc_out", acc_out[0], 72'h0);
    chk("rst_mul_a", 72'(mul_a[0]), 72'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_before_edge", 72'(in_ready[0]), 72'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("in_ready_after_release", 72'(in_ready[0]), 72'h1);
    tick(1);

    // Back-to-back frame with a wrapping-free large product
    send(0, 32'd1, 32'd1);
    send(0, 32'd2, 32'd3);
    send(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send(0, 32'd0, 32'd5);
    push(0, 72'h00_FFFF_FFFE_0000_0008, 1'b0);
    @(negedge clk);
    chk("in_ready_drop", 72'(in_ready[0]), 72'h0);
    tick(1);
    wait_drain();

    // Same frame with a stalled consumer
    out_ready[0] = 1'b0;
    send(0, 32'd1, 32'd1);
    send(0, 32'd2, 32'd3);
    send(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send(0, 32'd0, 32'd5);
    push(0, 72'h00_FFFF_FFFE_0000_0008, 1'b0);
    wait_ov(0);
    for (int k = 0; k < 10; k++) begin
      chk("hold_out_valid", 72'(out_valid[0]), 72'h1);
      chk("hold_in_ready", 72'(in_ready[0]), 72'h0);
      chk("hold_acc_out", acc_out[0], 72'h00_FFFF_FFFE_0000_0008);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    tick(1);
    @(negedge clk);
    chk("in_ready_after_drain", 72'(in_ready[0]), 72'h1);
    tick(1);
    send(0, 32'd1, 32'd1);
    send(0, 32'd2, 32'd2);
    send(0, 32'd3, 32'd3);
    send(0, 32'd4, 32'd4);
    push(0, 72'd30, 1'b0);
    wait_drain();

    // No guard bits: overflow then a clean frame
    send(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push(1, 72'h00_FFFF_FFFC_0000_0002, 1'b1);
    send(1, 32'd1, 32'd1);
    send(1, 32'd1, 32'd1);
    push(1, 72'd2, 1'b0);
    wait_drain();

    // Bubbles between accepts: in_valid 1,0,0,1,0,1
    send(2, 32'd7, 32'd9);
    tick(2);
    send(2, 32'd10, 32'd10);
    tick(1);
    send(2, 32'd3, 32'd3);
    push(2, 72'd172, 1'b0);
    wait_drain();
    tick(4);
    chk("single_pulse", 72'(hs_cnt[2]), 72'd1);

    // Abort mid-frame, then a fresh frame
    send(0, 32'd1, 32'd1);
    send(0, 32'd1, 32'd1);
    clr[0] = 1'b1;
    tick(1);
    clr[0] = 1'b0;
    @(negedge clk);
    chk("clr_mul_a", 72'(mul_a[0]), 72'h0);
    chk("clr_acc_out", acc_out[0], 72'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("clr_no_out_valid", 72'(out_valid[0]), 72'h0);
    end
    tick(1);
    chk("clr_no_handshake", 72'(hs_cnt[0]), 72'd3);
    for (int k = 0; k < 4; k++) send(0, 32'd1, 32'd2);
    push(0, 72'd8, 1'b0);
    wait_drain();

    // Asynchronous reset mid-frame
    send(0, 32'd9, 32'd9);
    send(0, 32'd9, 32'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mul_a", 72'(mul_a[0]), 72'h0);
    chk("arst_in_ready", 72'(in_ready[0]), 72'h0);
    chk("arst_out_valid", 72'(out_valid[0]), 72'h0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    @(negedge clk);
    chk("arst_in_ready_release", 72'(in_ready[0]), 72'h1);
    tick(1);

    // Asynchronous reset while holding a result
    out_ready[0] = 1'b0;
    for (int k = 0; k < 4; k++) send(0, 32'd1, 32'd1);
    wait_ov(0);
    #2 rst_n = 1'b0;
    #1;
    chk("hold_rst_out_valid", 72'(out_valid[0]), 72'h0);
    chk("hold_rst_acc_out", acc_out[0], 72'h0);
    chk("hold_rst_ovf", 72'(ovf[0]), 72'h0);
    tick(2);
    out_ready[0] = 1'b1;
    rst_n = 1'b1;
    tick(2);
    send(0, 32'd5, 32'd6);
    send(0, 32'd7, 32'd8);
    send(0, 32'd0, 32'd0);
    send(0, 32'd1, 32'd1);
    push(0, 72'd87, 1'b0);
    wait_drain();
    tick(3);
    chk("total_handshakes_inst0", 72'(hs_cnt[0]), 72'd5);
    chk("queue_empty", 72'(exp_q.size()), 72'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
